adder9x_ctrl: RTL and testbench

Sequencer that feeds the shared adder9x datapath from a single serial operand stream. It collects nine N-bit operands over a valid/ready input handshake and holds them on the adder's op1..op9 bus. It waits out the adder's pipeline latency, captures the sum, and presents it on a valid/ready output handshake. It sits between an upstream operand source and one adder9x instance; the adder is instantiated outside this block.

---
 rtl/adder9x_ctrl_if.sv | 35 +++
 rtl/adder9x_ctrl.sv | 115 +++++++++++
 tb/tb_adder9x_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/adder9x_ctrl_if.sv
// Handshake and datapath bundle between an operand source, the adder9x_ctrl
// sequencer and the external adder9x instance. Frame counter with ADDER9X_CTRL_FRAME_CNT_EN.
interface adder9x_ctrl_if #(
  parameter int N = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic [9*N-1:0]   ops;
  logic [N-1:0]     add_res;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_data;
  logic             busy;
`ifdef ADDER9X_CTRL_FRAME_CNT_EN
  logic [15:0]      frame_cnt;
`endif

  // master: operand source, adder9x and result sink seen as one peer
  modport master (
    output in_valid, in_data, add_res, out_ready,
    input  in_ready, ops, out_valid, out_data, busy
`ifdef ADDER9X_CTRL_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

  modport slave (
    input  in_valid, in_data, add_res, out_ready,
    output in_ready, ops, out_valid, out_data, busy
`ifdef ADDER9X_CTRL_FRAME_CNT_EN
    , output frame_cnt
`endif
  );
endinterface

// File: rtl/adder9x_ctrl.sv
// Serial-to-parallel sequencer for adder9x: loads nine operands, waits out the adder
// latency, returns the sum. Optional frame counter under ADDER9X_CTRL_FRAME_CNT_EN.
//
// state  | meaning
// S_LOAD | accepting operand beats, index selects op1..op9
// S_WAIT | op bus frozen, counting adder latency
// S_OUT  | sum held on out_data until downstream accepts
module adder9x_ctrl #(
  parameter int N   = 8,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  adder9x_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [9*N-1:0] ops_q, ops_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      ops_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ops_q       <= ops_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ops_d       = ops_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          for (int k = 0; k < 9; k++) begin
            if (idx_q == 4'(k)) ops_d[k*N +: N] = bus.in_data;
          end
          if (idx_q == 4'd8) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_WAIT: begin
        // adder res is valid LAT edges after the op bus settled
        if (cnt_q == LAT_C) begin
          out_data_d  = bus.add_res;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.ops       = ops_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != S_LOAD) || (idx_q != 4'd0);

`ifdef ADDER9X_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_adder9x_ctrl.sv
// Directed bench for adder9x_ctrl with a one-stage adder9x model (LAT=1).
// Frame counter checks run when ADDER9X_CTRL_FRAME_CNT_EN is defined.
module tb_adder9x_ctrl;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  logic [N-1:0] add_pipe;

  adder9x_ctrl_if #(.N(N)) ifc ();

  adder9x_ctrl #(.N(N), .LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // adder9x model: one register stage, modulo-256 sum of the op bus
  always_ff @(posedge clk) begin
    logic [N-1:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) s = s + ifc.ops[k*N +: N];
    add_pipe <= s;
  end
  assign ifc.add_res = add_pipe;

  task automatic send_beat(input logic [N-1:0] d);
    int t;
    t = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    while (!ifc.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      $display("FAIL beat_timeout in_ready=%0b required 1", ifc.in_ready);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    @(negedge clk);
  endtask

  task automatic wait_result(output logic [N-1:0] d);
    int t;
    t = 0;
    while (!ifc.out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 40) $display("FAIL result_timeout out_valid=%0b required 1", ifc.out_valid);
    else passed++;
    d = ifc.out_data;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.ops !== '0 || ifc.busy !== 1'b0) begin
      $display("FAIL reset_state out_valid=%0b ops=%h busy=%0b required 0/0/0",
               ifc.out_valid, ifc.ops, ifc.busy);
    end else passed++;
    #4 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.in_ready !== 1'b1 || ifc.out_data !== 8'h00) begin
      $display("FAIL reset_release in_ready=%0b out_data=%h required 1/00",
               ifc.in_ready, ifc.out_data);
    end else passed++;
  endtask

  task automatic test_all_ones();
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_beat(8'hFF);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b1 || ifc.in_ready !== 1'b0) begin
      $display("FAIL ones_e0 out_valid=%0b busy=%0b in_ready=%0b required 0/1/0",
               ifc.out_valid, ifc.busy, ifc.in_ready);
    end else passed++;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0) $display("FAIL ones_e1 out_valid=%0b required 0", ifc.out_valid);
    else passed++;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== 8'hF7) begin
      $display("FAIL ones_e2 out_valid=%0b out_data=%h required 1/f7", ifc.out_valid, ifc.out_data);
    end else passed++;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      $display("FAIL ones_after out_valid=%0b in_ready=%0b busy=%0b required 0/1/0",
               ifc.out_valid, ifc.in_ready, ifc.busy);
    end else passed++;
  endtask

  task automatic test_ordered();
    int gaps [9] = '{0, 1, 2, 3, 0, 2, 1, 3, 0};
    logic [N-1:0] r;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      repeat (gaps[i]) @(negedge clk);
      send_beat(8'(i + 1));
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (ifc.ops[k*N +: N] !== 8'(k + 1))
        $display("FAIL ordered_op%0d got=%h required %h", k + 1, ifc.ops[k*N +: N], 8'(k + 1));
      else passed++;
    end
    wait_result(r);
    checks++;
    if (r !== 8'h2D) $display("FAIL ordered_sum got=%h required 2d", r);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [N-1:0] r;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_beat(8'(i + 1));
    wait_result(r);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== 8'h2D || ifc.in_ready !== 1'b0 ||
          ifc.ops[7:0] !== 8'h01) begin
        $display("FAIL bp_hold%0d out_valid=%0b out_data=%h in_ready=%0b op1=%h required 1/2d/0/01",
                 c, ifc.out_valid, ifc.out_data, ifc.in_ready, ifc.ops[7:0]);
      end else passed++;
    end
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin
      $display("FAIL bp_release out_valid=%0b in_ready=%0b busy=%0b required 0/1/0",
               ifc.out_valid, ifc.in_ready, ifc.busy);
    end else passed++;
    for (int i = 0; i < 9; i++) send_beat(8'h02);
    wait_result(r);
    checks++;
    if (r !== 8'h12) $display("FAIL bp_next_sum got=%h required 12", r);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [N-1:0] r;
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(8'h10);
    checks++;
    if (ifc.busy !== 1'b1) $display("FAIL mid_busy busy=%0b required 1", ifc.busy);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.ops !== '0 || ifc.out_valid !== 1'b0) begin
      $display("FAIL mid_reset busy=%0b ops=%h out_valid=%0b required 0/0/0",
               ifc.busy, ifc.ops, ifc.out_valid);
    end else passed++;
    #4 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) send_beat(8'h01);
    wait_result(r);
    checks++;
    if (r !== 8'h09) $display("FAIL mid_new_sum got=%h required 09", r);
    else passed++;
    @(negedge clk);
  endtask

`ifdef ADDER9X_CTRL_FRAME_CNT_EN
  task automatic run_frame();
    logic [N-1:0] r;
    for (int i = 0; i < 9; i++) send_beat(8'h03);
    wait_result(r);
    @(negedge clk);
  endtask

  task automatic test_frame_cnt();
    ifc.out_ready = 1'b1;
    // one frame completed since the mid-frame reset, two more here
    run_frame();
    run_frame();
    checks++;
    if (ifc.frame_cnt !== 16'd3) $display("FAIL frame_cnt_3 got=%0d required 3", ifc.frame_cnt);
    else passed++;
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    run_frame();
    checks++;
    if (ifc.frame_cnt !== 16'h0000) $display("FAIL frame_cnt_wrap got=%h required 0000", ifc.frame_cnt);
    else passed++;
  endtask
`endif

  initial begin
    checks        = 0;
    passed        = 0;
    rst           = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b1;
    test_reset();
    test_all_ones();
    test_ordered();
    test_backpressure();
    test_reset_mid_frame();
`ifdef ADDER9X_CTRL_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
